// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP over one shared
// memory port. Outputs are decoded from state plus opcode.
// Optional feature macro: CTRL_MEM_HANDSHAKE_EN enables mem_ready waiting and
// the memory watchdog. Without it, every access completes in its first cycle.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] cause_q, cause_nxt;
  logic       mem_done;
  logic       mem_timeout;
  logic       legal_op;

`ifdef CTRL_MEM_HANDSHAKE_EN
  logic [CNT_W-1:0] wait_cnt;

  assign mem_done    = mem_ready;
  assign mem_timeout = !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  // Watchdog: counts stalled access cycles; zero whenever no access is waiting
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if ((state == S_FETCH || state == S_MEM) && !mem_ready && !mem_timeout)
      wait_cnt <= wait_cnt + CNT_W'(1);
    else
      wait_cnt <= '0;
  end
`else
  logic [CNT_W-1:0] unused_cfg;

  assign mem_done    = 1'b1;
  assign mem_timeout = 1'b0;
  assign unused_cfg  = CNT_W'(MEM_TIMEOUT) ^ {CNT_W{mem_ready}};
`endif

  assign legal_op = (opcode == OPC_R)      || (opcode == OPC_IMM)   ||
                    (opcode == OPC_LOAD)   || (opcode == OPC_STORE) ||
                    (opcode == OPC_BRANCH) || (opcode == OPC_JAL)   ||
                    (opcode == OPC_JALR)   || (opcode == OPC_LUI)   ||
                    (opcode == OPC_AUIPC);

  // State and latched trap cause
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  // Next-state and datapath controls; reset forces every output low
  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause_q;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 1'b0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    instr_done   = 1'b0;
    trap         = 1'b0;
    trap_cause   = cause_q;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_done) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (mem_timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        state_nxt = S_WB;
        case (opcode)
          OPC_R:   alu_op = 2'b10;
          OPC_IMM: begin alu_src_b = 1'b1; alu_op = 2'b11; end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b = 1'b1;
            state_nxt = S_MEM;
          end
          OPC_BRANCH: begin
            alu_op     = 2'b01;
            pc_write   = branch_cond;
            pc_src     = 2'b01;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
          OPC_JAL: begin pc_write = 1'b1; pc_src = 2'b01; end
          OPC_JALR: begin
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 2'b10;
          end
          OPC_LUI: ;
          OPC_AUIPC: begin alu_src_a = 2'b01; alu_src_b = 1'b1; end
          default: begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OPC_STORE);
        if (mem_done) begin
          if (opcode == OPC_STORE) begin
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt  = S_WB;
          end
        end else if (mem_timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
        case (opcode)
          OPC_LOAD:          wb_sel = 2'b01;
          OPC_JAL, OPC_JALR: wb_sel = 2'b10;
          OPC_LUI:           wb_sel = 2'b11;
          default:           wb_sel = 2'b00;
        endcase
      end
      S_TRAP: trap = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
    if (rst) begin
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      ir_write     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_src_a    = 2'b00;
      alu_src_b    = 1'b0;
      alu_op       = 2'b00;
      reg_write    = 1'b0;
      wb_sel       = 2'b00;
      instr_done   = 1'b0;
      trap         = 1'b0;
      trap_cause   = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected control vectors are queued
// with each driven cycle and compared against the DUT outputs on the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_cond;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_req, mem_we, mem_addr_sel;
  logic       alu_src_b, reg_write, instr_done, trap;
  logic [1:0] pc_src, alu_src_a, alu_op, wb_sel, trap_cause;

  int checks   = 0;
  int failures = 0;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // [18] pc_write [17:16] pc_src [15] ir_write [14] mem_req [13] mem_we
  // [12] mem_addr_sel [11:10] alu_src_a [9] alu_src_b [8:7] alu_op
  // [6] reg_write [5:4] wb_sel [3] instr_done [2] trap [1:0] trap_cause
  localparam logic [18:0] NONE   = 19'd0;
  localparam logic [18:0] PCW    = 19'd1 << 18;
  localparam logic [18:0] PCS_BR = 19'd1 << 16;
  localparam logic [18:0] PCS_JR = 19'd2 << 16;
  localparam logic [18:0] IRW    = 19'd1 << 15;
  localparam logic [18:0] MREQ   = 19'd1 << 14;
  localparam logic [18:0] MWE    = 19'd1 << 13;
  localparam logic [18:0] MADR   = 19'd1 << 12;
  localparam logic [18:0] SA_PC  = 19'd1 << 10;
  localparam logic [18:0] SB_IMM = 19'd1 << 9;
  localparam logic [18:0] AOP_BR = 19'd1 << 7;
  localparam logic [18:0] AOP_R  = 19'd2 << 7;
  localparam logic [18:0] AOP_I  = 19'd3 << 7;
  localparam logic [18:0] RW     = 19'd1 << 6;
  localparam logic [18:0] WB_MEM = 19'd1 << 4;
  localparam logic [18:0] WB_PC4 = 19'd2 << 4;
  localparam logic [18:0] WB_IMM = 19'd3 << 4;
  localparam logic [18:0] DONE   = 19'd1 << 3;
  localparam logic [18:0] TRP    = 19'd1 << 2;
  localparam logic [18:0] C_ILL  = 19'd1;
  localparam logic [18:0] C_TMO  = 19'd2;

  localparam logic [18:0] FETCH_OK = MREQ | IRW | PCW;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] JL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP = 7'b1100111;
  localparam logic [6:0] LU_OP = 7'b0110111;
  localparam logic [6:0] AU_OP = 7'b0010111;

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  function automatic logic [18:0] observed();
    return {pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
            alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
            instr_done, trap, trap_cause};
  endfunction

  // One clock cycle: drive inputs, queue expectation, compare on falling edge
  task automatic cyc(input string tag, input logic r, input logic rdy,
                     input logic bc, input logic [18:0] exp);
    sb_entry_t e;
    logic [18:0] obs;
    rst         = r;
    mem_ready   = rdy;
    branch_cond = bc;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    e   = sb_q.pop_front();
    obs = observed();
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; opcode = R_OP; branch_cond = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_outputs", 1, 1, 0, NONE);

    // R-type
    opcode = R_OP;
    cyc("r_fetch",  0, 1, 0, FETCH_OK);
    cyc("r_decode", 0, 1, 0, NONE);
    cyc("r_exec",   0, 1, 0, AOP_R);
    cyc("r_wb",     0, 1, 0, RW | DONE);

    // Load, with three stalled memory cycles when the handshake is built in
    opcode = LD_OP;
    cyc("ld_fetch",  0, 1, 0, FETCH_OK);
    cyc("ld_decode", 0, 1, 0, NONE);
    cyc("ld_exec",   0, 1, 0, SB_IMM);
`ifdef CTRL_MEM_HANDSHAKE_EN
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 0, 0, 0, MREQ | MADR);
`endif
    cyc("ld_mem",    0, 1, 0, MREQ | MADR);
    cyc("ld_wb",     0, 1, 0, RW | WB_MEM | DONE);

    // Branch taken, then not taken
    opcode = BR_OP;
    cyc("bt_fetch",  0, 1, 1, FETCH_OK);
    cyc("bt_decode", 0, 1, 1, NONE);
    cyc("bt_exec",   0, 1, 1, AOP_BR | PCW | PCS_BR | DONE);
    cyc("bn_fetch",  0, 1, 0, FETCH_OK);
    cyc("bn_decode", 0, 1, 0, NONE);
    cyc("bn_exec",   0, 1, 0, AOP_BR | PCS_BR | DONE);

    // Store
    opcode = ST_OP;
    cyc("st_fetch", 0, 1, 0, FETCH_OK);
    cyc("st_decode",0, 1, 0, NONE);
    cyc("st_exec",  0, 1, 0, SB_IMM);
    cyc("st_mem",   0, 1, 0, MREQ | MADR | MWE | DONE);

    // JAL, JALR, LUI, AUIPC, OP-IMM
    opcode = JL_OP;
    cyc("jal_fetch", 0, 1, 0, FETCH_OK);
    cyc("jal_decode",0, 1, 0, NONE);
    cyc("jal_exec",  0, 1, 0, PCW | PCS_BR);
    cyc("jal_wb",    0, 1, 0, RW | WB_PC4 | DONE);
    opcode = JR_OP;
    cyc("jalr_fetch", 0, 1, 0, FETCH_OK);
    cyc("jalr_decode",0, 1, 0, NONE);
    cyc("jalr_exec",  0, 1, 0, SB_IMM | PCW | PCS_JR);
    cyc("jalr_wb",    0, 1, 0, RW | WB_PC4 | DONE);
    opcode = LU_OP;
    cyc("lui_fetch", 0, 1, 0, FETCH_OK);
    cyc("lui_decode",0, 1, 0, NONE);
    cyc("lui_exec",  0, 1, 0, NONE);
    cyc("lui_wb",    0, 1, 0, RW | WB_IMM | DONE);
    opcode = AU_OP;
    cyc("auipc_fetch", 0, 1, 0, FETCH_OK);
    cyc("auipc_decode",0, 1, 0, NONE);
    cyc("auipc_exec",  0, 1, 0, SA_PC | SB_IMM);
    cyc("auipc_wb",    0, 1, 0, RW | DONE);
    opcode = I_OP;
    cyc("opimm_fetch", 0, 1, 0, FETCH_OK);
    cyc("opimm_decode",0, 1, 0, NONE);
    cyc("opimm_exec",  0, 1, 0, SB_IMM | AOP_I);
    cyc("opimm_wb",    0, 1, 0, RW | DONE);

    // Reset in the MEM cycle of a store abandons it
    opcode = ST_OP;
    cyc("strst_fetch", 0, 1, 0, FETCH_OK);
    cyc("strst_decode",0, 1, 0, NONE);
    cyc("strst_exec",  0, 1, 0, SB_IMM);
    cyc("strst_mem",   1, 1, 0, NONE);
    cyc("strst_refetch", 0, 1, 0, FETCH_OK);
    cyc("strst_decode2", 0, 1, 0, NONE);
    cyc("strst_exec2",   0, 1, 0, SB_IMM);
    cyc("strst_mem2",    0, 1, 0, MREQ | MADR | MWE | DONE);

    // Illegal opcode traps and stays trapped until reset
    opcode = 7'b0000000;
    cyc("ill_fetch",  0, 1, 0, FETCH_OK);
    cyc("ill_decode", 0, 1, 0, NONE);
    for (int i = 0; i < 20; i++) cyc("ill_trap", 0, 1, 1, TRP | C_ILL);
    cyc("ill_rst",    1, 1, 0, NONE);
    opcode = R_OP;
    cyc("ill_refetch",0, 1, 0, FETCH_OK);
    cyc("ill_decode2",0, 1, 0, NONE);
    cyc("ill_exec2",  0, 1, 0, AOP_R);
    cyc("ill_wb2",    0, 1, 0, RW | DONE);

`ifdef CTRL_MEM_HANDSHAKE_EN
    // Fetch stalls 16 cycles: watchdog trap
    for (int i = 0; i < 16; i++) cyc("tmo_wait", 0, 0, 0, MREQ);
    for (int i = 0; i < 3; i++)  cyc("tmo_trap", 0, 0, 0, TRP | C_TMO);
    cyc("tmo_rst", 1, 0, 0, NONE);
    // Ready arrives on the 16th cycle: completion wins over the timeout
    for (int i = 0; i < 15; i++) cyc("late_wait", 0, 0, 0, MREQ);
    cyc("late_done",   0, 1, 0, FETCH_OK);
    cyc("late_decode", 0, 1, 0, NONE);
    cyc("late_exec",   0, 1, 0, AOP_R);
    cyc("late_wb",     0, 1, 0, RW | DONE);
`else
    // Without the handshake, mem_ready is ignored
    cyc("noready_fetch", 0, 0, 0, FETCH_OK);
    cyc("noready_decode",0, 0, 0, NONE);
    cyc("noready_exec",  0, 0, 0, AOP_R);
    cyc("noready_wb",    0, 0, 0, RW | DONE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle RISC-V RV32I control FSM, the successor to the single-cycle opcode decoder. Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB over one shared memory port and ALU, and drives the datapath muxes and enables per state. Adds LUI/AUIPC, illegal-opcode trapping, an instruction-retire pulse and an optional memory ready handshake with a watchdog. Sits between the instruction register and the multicycle datapath.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles on `mem_ready` before a trap; range 1..255.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0], stable from DECODE until the next FETCH
- branch_cond  in  1  ALU comparison result for the current branch (funct3 already applied)
- mem_ready  in  1  memory accepts/completes the current request
- pc_write  out  1  load the PC
- pc_src  out  2  00 PC+4, 01 branch/JAL target (old_pc+imm), 10 ALU result with bit0 cleared (JALR)
- ir_write  out  1  load IR and old_pc
- mem_req  out  1  memory access request
- mem_we  out  1  write (store) when mem_req is high
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- alu_src_a  out  2  00 rs1, 01 old_pc, 10 zero
- alu_src_b  out  1  0 rs2, 1 immediate
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- reg_write  out  1  write rd
- wb_sel  out  2  00 ALU result, 01 memory data, 10 old_pc+4, 11 immediate
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- trap  out  1  FSM in TRAP
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded combinationally from state plus opcode; any output not listed for a state is 0.
- FETCH: mem_req=1, mem_addr_sel=0; on completion: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 go to EXEC; anything else goes to TRAP with cause 01.
- EXEC by opcode:
  - R: alu_op=10 -> WB. OP-IMM: alu_src_b=1, alu_op=11 -> WB. LOAD/STORE: alu_src_b=1, alu_op=00 -> MEM.
  - BRANCH: alu_op=01; pc_write=branch_cond, pc_src=01; instr_done=1 -> FETCH.
  - JAL: pc_write=1, pc_src=01 -> WB. JALR: alu_src_b=1, alu_op=00, pc_write=1, pc_src=10 -> WB.
  - LUI: -> WB. AUIPC: alu_src_a=01, alu_src_b=1, alu_op=00 -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE; on completion LOAD -> WB, STORE -> FETCH with instr_done=1.
- WB: reg_write=1; wb_sel = 01 LOAD, 10 JAL/JALR, 11 LUI, 00 otherwise; instr_done=1 -> FETCH.
- TRAP: trap=1, trap_cause held; all datapath enables 0; stays in TRAP until rst.
- Latency in cycles with zero memory waits: branch 3, R/I/JAL/JALR/LUI/AUIPC/store 4, load 5.

## Timing
- During a cycle with rst=1 all outputs are forced to 0. On the first edge with rst=1, state becomes FETCH, the wait counter becomes 0 and trap_cause becomes 00.
- Asserting rst in the middle of an instruction abandons it; no pc_write or reg_write is issued in that cycle.
- Memory completion happens in a cycle where mem_req=1 and mem_ready=1. Enables (ir_write, pc_write) fire only in that cycle. mem_req, mem_we and mem_addr_sel stay stable while waiting.
- Wait counter: cleared on entering FETCH or MEM and on completion; increments each cycle with mem_req=1 and mem_ready=0. If the counter equals MEM_TIMEOUT while mem_ready=0, the next state is TRAP with cause 10. A completion in the same cycle takes priority over the timeout.

## Configuration
- CTRL_MEM_HANDSHAKE_EN defined: FETCH and MEM wait on mem_ready, and the watchdog/timeout trap is active.
- CTRL_MEM_HANDSHAKE_EN undefined: mem_ready is ignored, every access completes in its first cycle, the counter is removed, and trap_cause 10 is unreachable.

## Test plan
- Reset, then R-type 0110011 with mem_ready tied to 1 -> states F,D,E,W; reg_write=1 in cycle 4 with wb_sel=00; instr_done pulses exactly once.
- Load 0000011 with mem_ready low for 3 cycles in MEM -> mem_req and mem_addr_sel=1 held for 4 cycles; WB with wb_sel=01; total 8 cycles.
- Branch 1100011 with branch_cond=1, then again with 0 -> pc_write=1/pc_src=01 in EXEC, then pc_write=0; 3 cycles each.
- Opcode 0000000 -> TRAP after DECODE, trap=1, trap_cause=01, no further enables for 20 cycles; rst returns the FSM to FETCH.
- mem_ready held 0 in FETCH (macro on, MEM_TIMEOUT=15) -> TRAP with cause 10 after 16 waiting cycles; mem_ready=1 on cycle 16 instead -> normal DECODE.
- rst asserted in MEM of a store -> mem_req and mem_we drop in that cycle; FETCH follows next cycle.
